spi_slave_sysclk: RTL and testbench
===================================

# spi_slave_sysclk

System-clock-domain SPI responder: oversamples `sclk`/`cs_n`/`mosi` on `clk`, supports all four CPOL/CPHA modes, and exchanges `DATA_WIDTH`-bit MSB-first words with an SPI master. It sits on the peripheral side of an SPI link. Local logic supplies reply words through a valid/ready holding register and receives assembled words as single-cycle pulses.

## Interface
- `DATA_WIDTH`, 8: word length in bits.
- `SYNC_STAGES`, 2: synchronizer flops on `sclk`, `cs_n` and `mosi`. Minimum 2.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sclk`  in  1  SPI clock from master (asynchronous).
- `cs_n`  in  1  chip select, active low (asynchronous).
- `mosi`  in  1  master-out data (asynchronous).
- `miso`  out  1  slave-out data, `tx_shift[DATA_WIDTH-1]`.
- `miso_oe`  out  1  high while the synchronized `cs_n` is low; the top level tristates `miso` with it.
- `CPOL`, `CPHA`  in  1 each  mode select; must be stable while `cs_n` is low.
- `tx_data`  in  DATA_WIDTH  reply word.
- `tx_valid`  in  1  reply word offered.
- `tx_ready`  out  1  holding register empty.
- `rx_data`  out  DATA_WIDTH  last received word.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `busy`  out  1  state is XFER.
- `underrun`  out  1  one-cycle pulse (see Configuration).

## Operation
**Synchronization and edges**
- `sclk`, `cs_n` and `mosi` each pass through `SYNC_STAGES` flops. Edges are detected on the synchronized `sclk`.
- Leading edge: rising when CPOL=0, falling when CPOL=1. Trailing edge is the opposite.
- Sample edge: leading when CPHA=0, trailing when CPHA=1. Shift edge is the other one.

**Holding register**
- `tx_ready` = hold empty.
- On `tx_valid && tx_ready` the hold captures `tx_data` and becomes full.

**States**
- IDLE:
  - Waits for the synchronized `cs_n` to fall, then goes to XFER.
  - On entry to XFER it performs a word load.
- XFER:
  - Sample edge: `rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s}`, `bit_cnt++`.
  - When `bit_cnt` reaches `DATA_WIDTH`: `rx_data <= ` the assembled word, `rx_valid` pulses, `bit_cnt <= 0`, and a word boundary is armed.
  - Shift edge:
    - CPHA=0: if a boundary is armed, perform a word load; otherwise shift `tx_shift` left by 1.
    - CPHA=1: the word load happens at the boundary itself. The first shift edge of each word does not shift, because the MSB is already on `miso`. Later shift edges shift left by 1.
  - A synchronized `cs_n` rise goes to IDLE.

**Word load**
- Hold full: `tx_shift <= hold`, and the hold is emptied.
- Hold empty: `tx_shift <= 0` and `underrun` pulses.

**Boundary cases**
- Abort (`cs_n` rises mid-word): partial `rx_shift` is discarded, no `rx_valid`, `bit_cnt` cleared. The word already loaded into `tx_shift` is lost; the hold is untouched.
- Continuous transfer: any number of words while `cs_n` stays low.
- Simultaneous hold accept and word load in the same cycle: the load takes the old hold contents, the hold captures the new word, and `tx_ready` stays low.
- Reset asserted mid-transfer: all state returns to the reset values. The design must tolerate `sclk` activity while `rst` is high.

## Timing
- Reset values:
  - `miso`, `miso_oe`, `tx_ready` = 0,1 pattern as follows: `miso`=0, `miso_oe`=0, `tx_ready`=1.
  - `rx_data`=0, `rx_valid`=0, `busy`=0, `underrun`=0.
  - State IDLE, hold empty, `bit_cnt`=0.
  - Synchronizers reset to `cs_n`=1, `sclk`=0.
- Input timing:
  - `sclk` high and low phases must each be at least `SYNC_STAGES+2` `clk` periods.
  - `cs_n` setup to the first edge, and hold after the last edge, must each be at least `SYNC_STAGES+2` `clk` periods.
- Latencies:
  - `rx_valid` asserts `SYNC_STAGES+1` `clk` cycles after the final sample edge at the pin.
  - `miso` changes `SYNC_STAGES+1` cycles after a shift edge, or after `cs_n` falls.
  - `tx_ready` deasserts the cycle after the handshake.

## Configuration
- `SPI_SLAVE_UNDERRUN_EN` defined: `underrun` pulses for 1 cycle on every word load from an empty hold.
- Not defined: `underrun` is tied to 0 and the pulse logic is removed. Zero fill of `tx_shift` is unchanged.

## Structure
- Package `spi_pkg` holds:
  - the state encoding (IDLE, XFER);
  - mode constants (MODE0..MODE3 as {CPOL,CPHA});
  - a `bit_cnt` width helper, `$clog2(DATA_WIDTH+1)`.
- Sub-module `spi_sync`: an N-stage synchronizer with a reset-value parameter, instantiated three times.

## Test plan
- Mode 0: hold=0xA5, master sends 0x3C -> master reads 0xA5; `rx_data`=0x3C with one `rx_valid` pulse; `tx_ready` returns to 1.
- Mode 3: hold=0x81, master sends 0x7E -> master reads 0x81; `rx_data`=0x7E.
- Mode 1: hold=0x11, then 0x22 loaded mid-word, two back-to-back words with `cs_n` low throughout -> master reads 0x11 then 0x22; `rx_valid` pulses twice.
- Abort: `cs_n` rises after 4 bits of 0xF0 -> no `rx_valid`, `rx_data` unchanged, state IDLE; the next full transfer completes correctly.
- Underrun (macro on): empty hold, transfer 0x55 -> `miso` all 0, `underrun` pulses once, `rx_data`=0x55. Macro off: `underrun` stays 0.
- `rst` pulsed mid-word in mode 2 -> all outputs at reset values; the next transfer works.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the system-clock SPI responder.
package spi_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage single-bit synchronizer with a configurable reset value.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_slave_sysclk.sv
// SPI responder oversampling sclk/cs_n/mosi on clk, all four CPOL/CPHA modes.
// Define SPI_SLAVE_UNDERRUN_EN to enable the underrun pulse output.
module spi_slave_sysclk
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  underrun
);

    localparam int              CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .i_d (sclk),
        .o_q (w_sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .i_d (cs_n),
        .o_q (w_cs_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .i_d (mosi),
        .o_q (w_mosi_s)
    );

    state_t                r_state;
    logic                  r_sclk_d;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_full;
    logic                  r_armed;
    logic                  r_first;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_sample_edge;
    logic w_shift_edge;
    logic w_last_bit;
    logic w_in_xfer;
    logic w_load;
    logic w_accept;

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_sample_edge = 1'b0;
        w_shift_edge  = 1'b0;
        case ({CPOL, CPHA})
            MODE0, MODE3: begin
                w_sample_edge = w_sclk_rise;
                w_shift_edge  = w_sclk_fall;
            end
            MODE1, MODE2: begin
                w_sample_edge = w_sclk_fall;
                w_shift_edge  = w_sclk_rise;
            end
            default: ;
        endcase
    end

    assign w_last_bit = (r_bit_cnt == LAST_CNT);
    assign w_in_xfer  = (r_state == ST_XFER) && !w_cs_s;
    assign w_accept   = tx_valid && !r_hold_full;

    // CPHA=0 reloads on the shift edge after a boundary; CPHA=1 reloads on the final sample edge.
    assign w_load = ((r_state == ST_IDLE) && !w_cs_s) ||
                    (w_in_xfer && ((!CPHA && w_shift_edge && r_armed) ||
                                   (CPHA && w_sample_edge && w_last_bit)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sclk_d   <= 1'b0;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_armed    <= 1'b0;
            r_first    <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_sclk_d   <= w_sclk_s;
            r_rx_valid <= 1'b0;

            if (w_load) begin
                r_tx_shift <= r_hold_full ? r_hold : '0;
                r_first    <= 1'b1;
                r_armed    <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_cs_s) begin
                        r_state    <= ST_XFER;
                        r_bit_cnt  <= '0;
                        r_rx_shift <= '0;
                    end
                end
                ST_XFER: begin
                    if (w_cs_s) begin
                        r_state    <= ST_IDLE;
                        r_bit_cnt  <= '0;
                        r_rx_shift <= '0;
                        r_tx_shift <= '0;
                        r_armed    <= 1'b0;
                    end else begin
                        if (w_sample_edge) begin
                            r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
                            if (w_last_bit) begin
                                r_rx_data  <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
                                r_rx_valid <= 1'b1;
                                r_bit_cnt  <= '0;
                                r_armed    <= !CPHA;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                        // With CPHA=1 the freshly loaded MSB is already on miso at the first shift edge.
                        if (w_shift_edge && !w_load) begin
                            if (CPHA && r_first) begin
                                r_first <= 1'b0;
                            end else begin
                                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic r_underrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_load && !r_hold_full;
        end
    end

    assign underrun = r_underrun;
`else
    assign underrun = 1'b0;
`endif

    assign miso     = r_tx_shift[DATA_WIDTH-1];
    assign miso_oe  = ~w_cs_s;
    assign tx_ready = ~r_hold_full;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state == ST_XFER);

endmodule

// File: tb/tb_spi_slave_sysclk.sv
// Directed bench for spi_slave_sysclk: a bit-banged SPI master in all four modes.
module tb_spi_slave_sysclk;
    import spi_pkg::*;

    localparam int DW    = 8;
    localparam int SYNC  = 2;
    localparam int HALF  = 8;
    localparam int SETUP = 8;
    localparam int HOLD  = 8;
    localparam int GAP   = 12;
`ifdef SPI_SLAVE_UNDERRUN_EN
    localparam int EXP_URUN = 1;
`else
    localparam int EXP_URUN = 0;
`endif

    logic          clk;
    logic          rst;
    logic          sclk;
    logic          cs_n;
    logic          mosi;
    logic          miso;
    logic          miso_oe;
    logic          CPOL;
    logic          CPHA;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          underrun;

    spi_slave_sysclk #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .CPOL     (CPOL),
        .CPHA     (CPHA),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .underrun (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  rxv_cnt  = 0;
    int  urun_cnt = 0;
    time t_last_rxv = 0;
    time t_sample   = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            t_last_rxv = $time;
        end
        if (underrun) urun_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_put(input logic [DW-1:0] d);
        bit done = 1'b0;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (tx_ready) done = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        if (done) check("tx_ready_drop", 32'(tx_ready), 32'd0);
        else      check("hold_timeout", 32'd0, 32'd1);
    endtask

    task automatic frame_begin(input logic [1:0] mode);
        CPOL = mode[1];
        CPHA = mode[0];
        sclk = mode[1];
        wait_clk(4);
        cs_n = 1'b0;
        wait_clk(SETUP);
        check("busy_in_frame", 32'(busy), 32'd1);
        check("oe_in_frame", 32'(miso_oe), 32'd1);
    endtask

    task automatic frame_end();
        wait_clk(HOLD);
        cs_n = 1'b1;
        wait_clk(GAP);
        check("busy_after_frame", 32'(busy), 32'd0);
        check("oe_after_frame", 32'(miso_oe), 32'd0);
    endtask

    task automatic spi_bits(input logic [1:0] mode, input logic [DW-1:0] w,
                            input int nbits, output logic [DW-1:0] r);
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!mode[0]) begin
                mosi = w[DW-1-i];
                wait_clk(HALF);
                r = {r[DW-2:0], miso};
                sclk = ~mode[1];
                t_sample = $time;
                wait_clk(HALF);
                sclk = mode[1];
            end else begin
                sclk = ~mode[1];
                mosi = w[DW-1-i];
                wait_clk(HALF);
                r = {r[DW-2:0], miso};
                sclk = mode[1];
                t_sample = $time;
                wait_clk(HALF);
            end
        end
    endtask

    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    int            base_rxv;
    int            base_urun;

    initial begin
        rst      = 1'b1;
        sclk     = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        CPOL     = 1'b0;
        CPHA     = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(5);

        check("rst_miso", 32'(miso), 32'd0);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);

        // Mode 0 single word
        hold_put(8'hA5);
        base_rxv = rxv_cnt;
        frame_begin(MODE0);
        spi_bits(MODE0, 8'h3C, 8, r1);
        wait_clk(HALF);
        check("m0_rxv_latency", 32'(t_last_rxv - t_sample), 32'((SYNC + 1) * 10));
        frame_end();
        check("m0_miso_word", 32'(r1), 32'hA5);
        check("m0_rx_data", 32'(rx_data), 32'h3C);
        check("m0_rxv_count", 32'(rxv_cnt - base_rxv), 32'd1);
        check("m0_tx_ready", 32'(tx_ready), 32'd1);

        // Mode 3 single word
        hold_put(8'h81);
        base_rxv = rxv_cnt;
        frame_begin(MODE3);
        spi_bits(MODE3, 8'h7E, 8, r1);
        frame_end();
        check("m3_miso_word", 32'(r1), 32'h81);
        check("m3_rx_data", 32'(rx_data), 32'h7E);
        check("m3_rxv_count", 32'(rxv_cnt - base_rxv), 32'd1);

        // Mode 1 back-to-back words, second reply offered mid-word
        hold_put(8'h11);
        base_rxv = rxv_cnt;
        fork
            begin
                frame_begin(MODE1);
                spi_bits(MODE1, 8'hC6, 8, r1);
                spi_bits(MODE1, 8'h39, 8, r2);
                frame_end();
            end
            begin
                wait_clk(40);
                hold_put(8'h22);
            end
        join
        check("m1_miso_word0", 32'(r1), 32'h11);
        check("m1_miso_word1", 32'(r2), 32'h22);
        check("m1_rx_data", 32'(rx_data), 32'h39);
        check("m1_rxv_count", 32'(rxv_cnt - base_rxv), 32'd2);
        check("m1_tx_ready", 32'(tx_ready), 32'd1);

        // Abort after 4 bits, then a clean transfer
        hold_put(8'h5A);
        base_rxv = rxv_cnt;
        frame_begin(MODE0);
        spi_bits(MODE0, 8'hF0, 4, r1);
        frame_end();
        check("abort_rxv_count", 32'(rxv_cnt - base_rxv), 32'd0);
        check("abort_rx_data", 32'(rx_data), 32'h39);
        check("abort_tx_ready", 32'(tx_ready), 32'd1);
        hold_put(8'hC3);
        frame_begin(MODE0);
        spi_bits(MODE0, 8'h96, 8, r1);
        frame_end();
        check("post_abort_miso", 32'(r1), 32'hC3);
        check("post_abort_rx", 32'(rx_data), 32'h96);

        // Underrun: empty hold at frame start, refilled mid-word
        check("urun_hold_empty", 32'(tx_ready), 32'd1);
        base_urun = urun_cnt;
        fork
            begin
                frame_begin(MODE0);
                spi_bits(MODE0, 8'h55, 8, r1);
                frame_end();
            end
            begin
                wait_clk(40);
                hold_put(8'hEE);
            end
        join
        check("urun_miso_zero", 32'(r1), 32'h00);
        check("urun_rx_data", 32'(rx_data), 32'h55);
        check("urun_count", 32'(urun_cnt - base_urun), 32'(EXP_URUN));

        // Reset pulsed mid-word in mode 2 with sclk still toggling
        hold_put(8'h3D);
        base_rxv = rxv_cnt;
        fork
            begin
                frame_begin(MODE2);
                spi_bits(MODE2, 8'hAB, 8, r1);
                frame_end();
            end
            begin
                wait_clk(40);
                rst = 1'b1;
                wait_clk(4);
                check("midrst_miso", 32'(miso), 32'd0);
                check("midrst_oe", 32'(miso_oe), 32'd0);
                check("midrst_tx_ready", 32'(tx_ready), 32'd1);
                check("midrst_rx_data", 32'(rx_data), 32'd0);
                check("midrst_rx_valid", 32'(rx_valid), 32'd0);
                check("midrst_busy", 32'(busy), 32'd0);
                check("midrst_underrun", 32'(underrun), 32'd0);
                wait_clk(6);
                rst = 1'b0;
            end
        join
        check("midrst_rxv_count", 32'(rxv_cnt - base_rxv), 32'd0);
        hold_put(8'h6B);
        frame_begin(MODE2);
        spi_bits(MODE2, 8'h4E, 8, r1);
        frame_end();
        check("post_rst_miso", 32'(r1), 32'h6B);
        check("post_rst_rx", 32'(rx_data), 32'h4E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
